// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller.
package sprite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StMoveX,
    StMoveY,
    StDone
  } state_t;

  localparam int unsigned ScreenWDef = 640;
  localparam int unsigned ScreenHDef = 480;
  localparam int unsigned SpriteWDef = 32;
  localparam int unsigned SpriteHDef = 32;
  localparam int unsigned StepDef    = 4;
  localparam int unsigned MaxStepDef = 12;
  localparam int unsigned XInitDef   = 304;
  localparam int unsigned YInitDef   = 224;

  localparam int unsigned CoordW = 10;
  localparam int unsigned ArithW = 11;

  // Bit positions inside the 4-bit button / direction vectors.
  localparam int unsigned DirUp    = 0;
  localparam int unsigned DirDown  = 1;
  localparam int unsigned DirLeft  = 2;
  localparam int unsigned DirRight = 3;

  // One clamped move along an axis; opposing requests cancel out.
  function automatic logic [CoordW-1:0] move_axis(input logic [CoordW-1:0] pos,
                                                  input logic [ArithW-1:0] step,
                                                  input logic              dec,
                                                  input logic              inc,
                                                  input logic [ArithW-1:0] limit);
    logic [ArithW-1:0] wide;
    logic [ArithW-1:0] res;
    wide = {1'b0, pos};
    res  = wide;
    if (dec && !inc) begin
      res = (wide < step) ? '0 : wide - step;
    end else if (inc && !dec) begin
      res = (wide + step > limit) ? limit : wide + step;
    end
    return res[CoordW-1:0];
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the asynchronous direction buttons.
module btn_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] btn_async,
  output logic [Width-1:0] btn_synced
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_async;
      sync_q <= meta_q;
    end
  end

  assign btn_synced = sync_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Applies one clamped sprite move per frame at the start of vertical blanking.
// Optional per-axis acceleration is enabled by defining SPRITE_ACCEL_EN.
import sprite_pkg::*;

module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W = ScreenWDef,
  parameter int unsigned SCREEN_H = ScreenHDef,
  parameter int unsigned SPRITE_W = SpriteWDef,
  parameter int unsigned SPRITE_H = SpriteHDef,
  parameter int unsigned STEP     = StepDef,
  parameter int unsigned MAX_STEP = MaxStepDef,
  parameter int unsigned X_INIT   = XInitDef,
  parameter int unsigned Y_INIT   = YInitDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v_display,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [CoordW-1:0] sprite_x,
  output logic [CoordW-1:0] sprite_y,
  output logic              update_busy,
  output logic              frame_tick
);

  localparam logic [ArithW-1:0] XMax = ArithW'(SCREEN_W - SPRITE_W);
  localparam logic [ArithW-1:0] YMax = ArithW'(SCREEN_H - SPRITE_H);
  // The base step never exceeds the ceiling, even if misconfigured.
  localparam logic [ArithW-1:0] StepBase = ArithW'((STEP > MAX_STEP) ? MAX_STEP : STEP);
  localparam logic [ArithW-1:0] StepMax  = ArithW'(MAX_STEP);

  logic [3:0]        btn_raw;
  logic [3:0]        btn_s;
  logic              v_display_q;
  logic              vb_start;
  state_t            state_q;
  logic [3:0]        dir_q;
  logic [CoordW-1:0] x_q;
  logic [CoordW-1:0] y_q;
  logic              busy_q;
  logic              tick_q;
  logic [ArithW-1:0] step_x;
  logic [ArithW-1:0] step_y;
  logic [CoordW-1:0] next_x;
  logic [CoordW-1:0] next_y;

  always_comb begin
    btn_raw           = '0;
    btn_raw[DirUp]    = btn_up;
    btn_raw[DirDown]  = btn_down;
    btn_raw[DirLeft]  = btn_left;
    btn_raw[DirRight] = btn_right;
  end

  btn_sync #(
    .Width(4)
  ) u_btn_sync (
    .clk       (clk),
    .reset     (reset),
    .btn_async (btn_raw),
    .btn_synced(btn_s)
  );

  assign vb_start = v_display_q & ~v_display;

  always_comb begin
    next_x = move_axis(x_q, step_x, dir_q[DirLeft], dir_q[DirRight], XMax);
    next_y = move_axis(y_q, step_y, dir_q[DirUp], dir_q[DirDown], YMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      v_display_q <= 1'b1;
      dir_q       <= '0;
      x_q         <= CoordW'(X_INIT);
      y_q         <= CoordW'(Y_INIT);
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      v_display_q <= v_display;
      tick_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (vb_start) begin
            state_q <= StLatch;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          dir_q   <= btn_s;
          state_q <= StMoveX;
        end
        StMoveX: begin
          x_q     <= next_x;
          state_q <= StMoveY;
        end
        StMoveY: begin
          y_q     <= next_y;
          tick_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StDone;
        end
        StDone: begin
          // Re-arm only once active video resumes, so one move per blank.
          if (v_display) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPRITE_ACCEL_EN
  // Direction request per axis as {negative, positive}; opposing presses give 2'b00.
  logic [1:0]        x_req;
  logic [1:0]        y_req;
  logic [1:0]        x_last_q;
  logic [1:0]        y_last_q;
  logic [2:0]        x_cnt_q;
  logic [2:0]        y_cnt_q;
  logic [ArithW-1:0] x_step_q;
  logic [ArithW-1:0] y_step_q;

  assign x_req = {btn_s[DirLeft] & ~btn_s[DirRight], btn_s[DirRight] & ~btn_s[DirLeft]};
  assign y_req = {btn_s[DirUp] & ~btn_s[DirDown], btn_s[DirDown] & ~btn_s[DirUp]};

  always_ff @(posedge clk) begin
    if (reset) begin
      x_last_q <= '0;
      y_last_q <= '0;
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x_step_q <= StepBase;
      y_step_q <= StepBase;
    end else if (state_q == StLatch) begin
      x_last_q <= x_req;
      y_last_q <= y_req;
      if (x_req == 2'b00 || x_req != x_last_q) begin
        x_cnt_q  <= '0;
        x_step_q <= StepBase;
      end else begin
        x_cnt_q <= x_cnt_q + 3'd1;
        if (x_cnt_q == 3'd7 && x_step_q < StepMax) begin
          x_step_q <= x_step_q + 1'b1;
        end
      end
      if (y_req == 2'b00 || y_req != y_last_q) begin
        y_cnt_q  <= '0;
        y_step_q <= StepBase;
      end else begin
        y_cnt_q <= y_cnt_q + 3'd1;
        if (y_cnt_q == 3'd7 && y_step_q < StepMax) begin
          y_step_q <= y_step_q + 1'b1;
        end
      end
    end
  end

  assign step_x = x_step_q;
  assign step_y = y_step_q;
`else
  assign step_x = StepBase;
  assign step_y = StepBase;
`endif

  assign sprite_x    = x_q;
  assign sprite_y    = y_q;
  assign update_busy = busy_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized self-checking bench for sprite_motion_ctrl against a frame-level position model.
module tb_sprite_motion_ctrl;

  localparam int XMAX     = 608;
  localparam int YMAX     = 448;
  localparam int STEP     = 4;
  localparam int MAX_STEP = 12;
  localparam int X_INIT   = 304;
  localparam int Y_INIT   = 224;

  logic       clk = 1'b0;
  logic       reset;
  logic       v_display;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] sprite_x, sprite_y;
  logic       update_busy, frame_tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: position, and per-axis count of consecutive frames in one direction.
  int mx, my;
  int run_x, run_y, last_x, last_y;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .v_display  (v_display),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .update_busy(update_busy),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b = {right, left, down, up}
  task automatic set_btns(input logic [3:0] b);
    btn_up    = b[0];
    btn_down  = b[1];
    btn_left  = b[2];
    btn_right = b[3];
  endtask

  function automatic int step_for(input int run);
`ifdef SPRITE_ACCEL_EN
    int s;
    s = STEP + (run - 1) / 8;
    return (s > MAX_STEP) ? MAX_STEP : s;
`else
    return (run > 0) ? STEP : 0;
`endif
  endfunction

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT;
    run_x = 0; run_y = 0; last_x = 0; last_y = 0;
  endtask

  task automatic model_frame(input logic [3:0] b);
    int dx, dy, s;
    dx = (b[3] && !b[2]) ? 1 : ((b[2] && !b[3]) ? -1 : 0);
    dy = (b[1] && !b[0]) ? 1 : ((b[0] && !b[1]) ? -1 : 0);
    run_x = (dx == 0) ? 0 : ((dx == last_x) ? run_x + 1 : 1);
    run_y = (dy == 0) ? 0 : ((dy == last_y) ? run_y + 1 : 1);
    last_x = dx; last_y = dy;
    s = step_for(run_x);
    if (dx > 0) mx = (mx + s > XMAX) ? XMAX : mx + s;
    else if (dx < 0) mx = (mx < s) ? 0 : mx - s;
    s = step_for(run_y);
    if (dy > 0) my = (my + s > YMAX) ? YMAX : my + s;
    else if (dy < 0) my = (my < s) ? 0 : my - s;
  endtask

  // One full frame: active video (optionally with button chatter), then the blank update.
  task automatic do_frame(input logic [3:0] b, input int toggles, input string tag);
    int px, py, ex, ey;
    px = mx; py = my;
    v_display = 1'b1;
    for (int i = 0; i < toggles; i++) begin
      set_btns(4'($urandom_range(0, 15)));
      tick();
      n_checks++;
      if (sprite_x !== 10'(px) || sprite_y !== 10'(py))
        $display("FAIL %s active-hold: got x=%0d y=%0d want x=%0d y=%0d",
                 tag, sprite_x, sprite_y, px, py);
      else n_pass++;
    end
    set_btns(b);
    repeat ($urandom_range(3, 8)) tick();
    model_frame(b);
    ex = mx; ey = my;
    v_display = 1'b0;
    tick();
    n_checks++;
    if (update_busy !== 1'b1 || sprite_x !== 10'(px) || sprite_y !== 10'(py))
      $display("FAIL %s latch: got busy=%0b x=%0d y=%0d want busy=1 x=%0d y=%0d",
               tag, update_busy, sprite_x, sprite_y, px, py);
    else n_pass++;
    tick();
    n_checks++;
    if (update_busy !== 1'b1 || sprite_x !== 10'(px))
      $display("FAIL %s move_x-entry: got busy=%0b x=%0d want busy=1 x=%0d",
               tag, update_busy, sprite_x, px);
    else n_pass++;
    tick();
    n_checks++;
    if (sprite_x !== 10'(ex) || sprite_y !== 10'(py) || frame_tick !== 1'b0 ||
        update_busy !== 1'b1)
      $display("FAIL %s x-update: got x=%0d y=%0d tick=%0b busy=%0b want x=%0d y=%0d tick=0 busy=1",
               tag, sprite_x, sprite_y, frame_tick, update_busy, ex, py);
    else n_pass++;
    tick();
    n_checks++;
    if (sprite_y !== 10'(ey) || frame_tick !== 1'b1 || update_busy !== 1'b0)
      $display("FAIL %s y-update: got y=%0d tick=%0b busy=%0b want y=%0d tick=1 busy=0",
               tag, sprite_y, frame_tick, update_busy, ey);
    else n_pass++;
    tick();
    n_checks++;
    if (frame_tick !== 1'b0)
      $display("FAIL %s tick-width: got tick=%0b want tick=0", tag, frame_tick);
    else n_pass++;
    repeat ($urandom_range(2, 6)) tick();
    n_checks++;
    if (sprite_x !== 10'(ex) || sprite_y !== 10'(ey) || update_busy !== 1'b0 ||
        frame_tick !== 1'b0)
      $display("FAIL %s blank-hold: got x=%0d y=%0d busy=%0b tick=%0b want x=%0d y=%0d busy=0 tick=0",
               tag, sprite_x, sprite_y, update_busy, frame_tick, ex, ey);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; v_display = 1'b1; set_btns(4'b0000);
    repeat (3) tick();
    n_checks++;
    if (sprite_x !== 10'(X_INIT) || sprite_y !== 10'(Y_INIT) || update_busy !== 1'b0 ||
        frame_tick !== 1'b0)
      $display("FAIL reset: got x=%0d y=%0d busy=%0b tick=%0b want x=%0d y=%0d busy=0 tick=0",
               sprite_x, sprite_y, update_busy, frame_tick, X_INIT, Y_INIT);
    else n_pass++;
    reset = 1'b0;
    model_reset();
    tick();
    do_frame(4'b0000, 0, "idle_frame0");
    do_frame(4'b0000, 0, "idle_frame1");
  endtask

  task automatic test_right_move();
    for (int f = 0; f < 3; f++) do_frame(4'b1000, 0, "right_held");
  endtask

  task automatic test_clamp();
    for (int f = 0; f < 100 && mx != XMAX; f++) do_frame(4'b1000, 0, "right_to_edge");
    do_frame(4'b1000, 0, "right_clamped");
    do_frame(4'b1000, 0, "right_clamped2");
    for (int f = 0; f < 100 && my != 0; f++) do_frame(4'b0001, 0, "up_to_edge");
    do_frame(4'b0001, 0, "up_clamped");
    do_frame(4'b0001, 0, "up_clamped2");
  endtask

  task automatic test_opposing();
    do_frame(4'b1110, 0, "lr_cancel_down");
    do_frame(4'b1110, 12, "lr_cancel_toggled");
    do_frame(4'b0011, 6, "ud_cancel");
    do_frame(4'b0110, 10, "toggle_diag");
  endtask

  task automatic test_reset_mid_update();
    v_display = 1'b1; set_btns(4'b1000);
    repeat (5) tick();
    v_display = 1'b0;
    tick();  // LATCH
    tick();  // MOVE_X
    reset = 1'b1;
    tick();
    n_checks++;
    if (sprite_x !== 10'(X_INIT) || sprite_y !== 10'(Y_INIT) || update_busy !== 1'b0 ||
        frame_tick !== 1'b0)
      $display("FAIL reset_mid: got x=%0d y=%0d busy=%0b tick=%0b want x=%0d y=%0d busy=0 tick=0",
               sprite_x, sprite_y, update_busy, frame_tick, X_INIT, Y_INIT);
    else n_pass++;
    v_display = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();
    do_frame(4'b1000, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++)
      do_frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), "random");
  endtask

`ifdef SPRITE_ACCEL_EN
  task automatic test_accel();
    for (int f = 0; f < 100 && my != 0; f++) do_frame(4'b0001, 0, "accel_to_top");
    do_frame(4'b0000, 0, "accel_release0");
    for (int f = 0; f < 20; f++) do_frame(4'b0010, 0, "accel_down");
    do_frame(4'b0000, 0, "accel_release");
    do_frame(4'b0010, 0, "accel_repress");
    for (int f = 0; f < 10; f++) do_frame(4'b1000, 0, "accel_right");
    do_frame(4'b0100, 0, "accel_reverse");
  endtask
`endif

  initial begin
    set_btns(4'b0000);
    reset = 1'b1;
    v_display = 1'b1;
    model_reset();
    test_reset();
    test_right_move();
    test_clamp();
    test_opposing();
    test_reset_mid_update();
    test_random();
`ifdef SPRITE_ACCEL_EN
    test_accel();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
